axi_rsp_flow_ctrl: RTL and testbench

Sink-side controller for the HMC AXI-4-Stream response channel: FPW flits per beat, with TUSER carrying the Valid/Hdr/Tail flag vectors.
- Owns TREADY through a flit-credit counter that mirrors the downstream response buffer.
- Tracks packet framing across beats and lanes, counts completed packets, and raises sticky framing errors.
- Sits between the controller's response AXI port and the response buffer/consumer.

---
 rtl/axi_rsp_fc_pkg.sv | 46 ++++
 rtl/axi_rsp_pkt_tracker.sv | 77 +++++++
 rtl/axi_rsp_flow_ctrl.sv | 103 ++++++++++
 tb/tb_axi_rsp_flow_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/axi_rsp_fc_pkg.sv
// Shared types and TUSER flag helpers for the HMC response flow controller.
// Flag helpers support up to MAX_FPW lanes; lanes at or above the live FPW read as zero.
package axi_rsp_fc_pkg;

    localparam int MAX_FPW  = 8;
    localparam int TU_W     = MAX_FPW * 16;
    localparam int TU_IDX_W = $clog2(TU_W);
    localparam int CNT_W    = $clog2(MAX_FPW + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } fsm_state_t;

    typedef logic [MAX_FPW-1:0] lane_vec_t;

    // Field 0 = Valid, 1 = Hdr, 2 = Tail; each field is fpw bits wide.
    function automatic lane_vec_t get_field(input logic [TU_W-1:0] tuser, input int fpw, input int field);
        lane_vec_t v;
        v = '0;
        for (int i = 0; i < MAX_FPW; i++) begin
            if (i < fpw) v[i] = tuser[TU_IDX_W'(field * fpw + i)];
        end
        return v;
    endfunction

    function automatic lane_vec_t get_valid(input logic [TU_W-1:0] tuser, input int fpw);
        return get_field(tuser, fpw, 0);
    endfunction

    function automatic lane_vec_t get_hdr(input logic [TU_W-1:0] tuser, input int fpw);
        return get_field(tuser, fpw, 1);
    endfunction

    function automatic lane_vec_t get_tail(input logic [TU_W-1:0] tuser, input int fpw);
        return get_field(tuser, fpw, 2);
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input lane_vec_t v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_FPW; i++) cnt = cnt + CNT_W'(v[i]);
        return cnt;
    endfunction

endpackage

// File: rtl/axi_rsp_pkt_tracker.sv
// Packet framing tracker: walks the valid lanes of each accepted beat in lane order,
// counts closed packets and holds the sticky framing errors.
//   state  | meaning
//   IDLE   | no packet open, next valid flit must carry Hdr
//   IN_PKT | header seen, waiting for the tail flit
module axi_rsp_pkt_tracker
    import axi_rsp_fc_pkg::*;
(
    input  logic        clk,
    input  logic        res,
    input  logic        beat_acc_i,
    input  lane_vec_t   valid_i,
    input  lane_vec_t   hdr_i,
    input  lane_vec_t   tail_i,
    input  logic        err_clr_i,
    output logic        in_pkt_o,
    output logic [31:0] pkt_cnt_o,
    output logic        err_no_hdr_o,
    output logic        err_hdr_in_pkt_o
);

    fsm_state_t       state_q, state_d;
    logic [31:0]      pkt_q, pkt_d;
    logic             no_hdr_q, no_hdr_d;
    logic             hdr_in_q, hdr_in_d;
    logic [CNT_W-1:0] closes;
    logic             no_hdr_evt, hdr_in_evt;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= IDLE;
            pkt_q    <= '0;
            no_hdr_q <= 1'b0;
            hdr_in_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pkt_q    <= pkt_d;
            no_hdr_q <= no_hdr_d;
            hdr_in_q <= hdr_in_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        closes     = '0;
        no_hdr_evt = 1'b0;
        hdr_in_evt = 1'b0;
        for (int i = 0; i < MAX_FPW; i++) begin
            if (beat_acc_i && valid_i[i]) begin
                if (hdr_i[i]) begin
                    // A header inside an open packet abandons it and restarts framing here.
                    if (state_d == IN_PKT) hdr_in_evt = 1'b1;
                    if (tail_i[i]) begin
                        closes  = closes + CNT_W'(1);
                        state_d = IDLE;
                    end else begin
                        state_d = IN_PKT;
                    end
                end else if (state_d == IDLE) begin
                    no_hdr_evt = 1'b1;
                end else if (tail_i[i]) begin
                    closes  = closes + CNT_W'(1);
                    state_d = IDLE;
                end
            end
        end
        pkt_d    = pkt_q + 32'(closes);
        no_hdr_d = no_hdr_evt | (no_hdr_q & ~err_clr_i);
        hdr_in_d = hdr_in_evt | (hdr_in_q & ~err_clr_i);
    end

    assign in_pkt_o         = (state_q == IN_PKT);
    assign pkt_cnt_o        = pkt_q;
    assign err_no_hdr_o     = no_hdr_q;
    assign err_hdr_in_pkt_o = hdr_in_q;

endmodule

// File: rtl/axi_rsp_flow_ctrl.sv
// HMC response-channel sink: credit-based TREADY, framing tracker, optional stall counter.
// Define AXI_RSP_FC_STATS_EN to build the stall counter; otherwise stall_cnt is tied to 0. FPW <= 8.
module axi_rsp_flow_ctrl
    import axi_rsp_fc_pkg::*;
#(
    parameter int FPW     = 2,
    parameter int CREDITS = 16,
    parameter int CRED_W  = $clog2(CREDITS + 1),
    parameter int RET_W   = $clog2(FPW + 1)
) (
    input  logic              clk,
    input  logic              res,
    input  logic              tvalid,
    input  logic [FPW*16-1:0] tuser,
    output logic              tready,
    input  logic [RET_W-1:0]  flit_ret,
    output logic [CRED_W-1:0] credit_cnt,
    output logic [31:0]       pkt_cnt,
    output logic              in_pkt,
    input  logic              err_clr,
    output logic              err_no_hdr,
    output logic              err_hdr_in_pkt,
    output logic              err_cred_ovf,
    output logic [31:0]       stall_cnt
);

    localparam int SUM_W = CRED_W + CNT_W + 1;

    logic [TU_W-1:0]   tuser_ext;
    lane_vec_t         valid_v, hdr_v, tail_v;
    logic              accept;
    logic [CNT_W-1:0]  acc;
    logic [SUM_W-1:0]  cred_sum;
    logic              ovf;
    logic [CRED_W-1:0] credit_q, credit_d;
    logic              tready_q, tready_d;
    logic              ovf_q, ovf_d;

    assign tuser_ext = TU_W'(tuser);
    assign valid_v   = get_valid(tuser_ext, FPW);
    assign hdr_v     = get_hdr(tuser_ext, FPW);
    assign tail_v    = get_tail(tuser_ext, FPW);
    assign accept    = tvalid & tready_q;

    // tready only rises with >= FPW credits, so the subtraction cannot underflow.
    always_comb begin
        acc      = accept ? popcount(valid_v) : '0;
        cred_sum = SUM_W'(credit_q) - SUM_W'(acc) + SUM_W'(flit_ret);
        ovf      = (cred_sum > SUM_W'(CREDITS));
        credit_d = ovf ? CRED_W'(CREDITS) : cred_sum[CRED_W-1:0];
        tready_d = (credit_d >= CRED_W'(FPW));
        ovf_d    = ovf | (ovf_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            credit_q <= CRED_W'(CREDITS);
            tready_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            tready_q <= tready_d;
            ovf_q    <= ovf_d;
        end
    end

    axi_rsp_pkt_tracker u_tracker (
        .clk              (clk),
        .res              (res),
        .beat_acc_i       (accept),
        .valid_i          (valid_v),
        .hdr_i            (hdr_v),
        .tail_i           (tail_v),
        .err_clr_i        (err_clr),
        .in_pkt_o         (in_pkt),
        .pkt_cnt_o        (pkt_cnt),
        .err_no_hdr_o     (err_no_hdr),
        .err_hdr_in_pkt_o (err_hdr_in_pkt)
    );

`ifdef AXI_RSP_FC_STATS_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (tvalid && !tready_q && (stall_q != '1)) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    assign tready       = tready_q;
    assign credit_cnt   = credit_q;
    assign err_cred_ovf = ovf_q;

endmodule

// File: tb/tb_axi_rsp_flow_ctrl.sv
// Self-checking bench for axi_rsp_flow_ctrl at FPW=2, CREDITS=8: vector table through a
// scoreboard queue, plus hand sequences for asynchronous reset mid-packet and stall counting.
module tb_axi_rsp_flow_ctrl;

    localparam int FPW     = 2;
    localparam int CREDITS = 8;
    localparam int CRED_W  = 4;
    localparam int RET_W   = 2;
    localparam int NVEC    = 26;

    logic              clk = 1'b0;
    logic              res;
    logic              tvalid;
    logic [FPW*16-1:0] tuser;
    logic              tready;
    logic [RET_W-1:0]  flit_ret;
    logic [CRED_W-1:0] credit_cnt;
    logic [31:0]       pkt_cnt;
    logic              in_pkt;
    logic              err_clr;
    logic              err_no_hdr;
    logic              err_hdr_in_pkt;
    logic              err_cred_ovf;
    logic [31:0]       stall_cnt;

    always #5 clk = ~clk;

    axi_rsp_flow_ctrl #(.FPW(FPW), .CREDITS(CREDITS)) dut (
        .clk            (clk),
        .res            (res),
        .tvalid         (tvalid),
        .tuser          (tuser),
        .tready         (tready),
        .flit_ret       (flit_ret),
        .credit_cnt     (credit_cnt),
        .pkt_cnt        (pkt_cnt),
        .in_pkt         (in_pkt),
        .err_clr        (err_clr),
        .err_no_hdr     (err_no_hdr),
        .err_hdr_in_pkt (err_hdr_in_pkt),
        .err_cred_ovf   (err_cred_ovf),
        .stall_cnt      (stall_cnt)
    );

    typedef struct {
        logic        tv;
        logic [1:0]  v, h, t, ret;
        logic        clr;
        logic [3:0]  cred;
        logic        rdy;
        logic [31:0] pkt;
        logic        inp, nh, hip, ovf;
    } vec_t;

    vec_t tbl [NVEC];
    vec_t sb_q [$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic tv, input logic [1:0] v, h, t, ret, input logic clr,
                                input logic [3:0] cred, input logic rdy, input logic [31:0] pkt,
                                input logic inp, nh, hip, ovf);
        vec_t x;
        x.tv = tv; x.v = v; x.h = h; x.t = t; x.ret = ret; x.clr = clr;
        x.cred = cred; x.rdy = rdy; x.pkt = pkt; x.inp = inp; x.nh = nh; x.hip = hip; x.ovf = ovf;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        tvalid   = x.tv;
        tuser    = {26'b0, x.t, x.h, x.v};
        flit_ret = x.ret;
        err_clr  = x.clr;
        sb_q.push_back(x);
    endtask

    task automatic compare_out(input int idx);
        vec_t e;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty step %0d", idx);
            return;
        end
        e = sb_q.pop_front();
        chk($sformatf("credit_cnt[%0d]", idx),     32'(credit_cnt),     32'(e.cred));
        chk($sformatf("tready[%0d]", idx),         32'(tready),         32'(e.rdy));
        chk($sformatf("pkt_cnt[%0d]", idx),        pkt_cnt,             e.pkt);
        chk($sformatf("in_pkt[%0d]", idx),         32'(in_pkt),         32'(e.inp));
        chk($sformatf("err_no_hdr[%0d]", idx),     32'(err_no_hdr),     32'(e.nh));
        chk($sformatf("err_hdr_in_pkt[%0d]", idx), 32'(err_hdr_in_pkt), 32'(e.hip));
        chk($sformatf("err_cred_ovf[%0d]", idx),   32'(err_cred_ovf),   32'(e.ovf));
    endtask

    initial begin
        //            tv  V      H      T      ret    clr   cred rdy pkt  in nh hip ovf
        tbl[0]  = mk(0, 2'b00, 2'b00, 2'b00, 2'd0, 0,   8, 1,  0,  0, 0, 0, 0);
        tbl[1]  = mk(1, 2'b11, 2'b11, 2'b11, 2'd0, 0,   6, 1,  2,  0, 0, 0, 0);
        tbl[2]  = mk(1, 2'b11, 2'b11, 2'b11, 2'd0, 0,   4, 1,  4,  0, 0, 0, 0);
        tbl[3]  = mk(1, 2'b11, 2'b11, 2'b11, 2'd0, 0,   2, 1,  6,  0, 0, 0, 0);
        tbl[4]  = mk(1, 2'b11, 2'b11, 2'b11, 2'd0, 0,   0, 0,  8,  0, 0, 0, 0);
        tbl[5]  = mk(1, 2'b11, 2'b11, 2'b11, 2'd1, 0,   1, 0,  8,  0, 0, 0, 0);
        tbl[6]  = mk(1, 2'b11, 2'b11, 2'b11, 2'd1, 0,   2, 1,  8,  0, 0, 0, 0);
        tbl[7]  = mk(0, 2'b00, 2'b00, 2'b00, 2'd3, 0,   5, 1,  8,  0, 0, 0, 0);
        tbl[8]  = mk(0, 2'b00, 2'b00, 2'b00, 2'd3, 0,   8, 1,  8,  0, 0, 0, 0);
        tbl[9]  = mk(1, 2'b11, 2'b01, 2'b00, 2'd0, 0,   6, 1,  8,  1, 0, 0, 0);
        tbl[10] = mk(1, 2'b01, 2'b00, 2'b01, 2'd0, 0,   5, 1,  9,  0, 0, 0, 0);
        tbl[11] = mk(1, 2'b01, 2'b10, 2'b10, 2'd0, 0,   4, 1,  9,  0, 1, 0, 0);
        tbl[12] = mk(1, 2'b01, 2'b01, 2'b00, 2'd0, 0,   3, 1,  9,  1, 1, 0, 0);
        tbl[13] = mk(1, 2'b01, 2'b01, 2'b00, 2'd0, 1,   2, 1,  9,  1, 0, 1, 0);
        tbl[14] = mk(0, 2'b00, 2'b00, 2'b00, 2'd2, 0,   4, 1,  9,  1, 0, 1, 0);
        tbl[15] = mk(1, 2'b11, 2'b00, 2'b01, 2'd0, 0,   2, 1, 10,  0, 1, 1, 0);
        tbl[16] = mk(0, 2'b00, 2'b00, 2'b00, 2'd0, 1,   2, 1, 10,  0, 0, 0, 0);
        tbl[17] = mk(1, 2'b11, 2'b01, 2'b10, 2'd0, 0,   0, 0, 11,  0, 0, 0, 0);
        tbl[18] = mk(0, 2'b00, 2'b00, 2'b00, 2'd2, 0,   2, 1, 11,  0, 0, 0, 0);
        tbl[19] = mk(0, 2'b00, 2'b00, 2'b00, 2'd2, 0,   4, 1, 11,  0, 0, 0, 0);
        tbl[20] = mk(0, 2'b00, 2'b00, 2'b00, 2'd2, 0,   6, 1, 11,  0, 0, 0, 0);
        tbl[21] = mk(0, 2'b00, 2'b00, 2'b00, 2'd1, 0,   7, 1, 11,  0, 0, 0, 0);
        tbl[22] = mk(0, 2'b00, 2'b00, 2'b00, 2'd2, 0,   8, 1, 11,  0, 0, 0, 1);
        tbl[23] = mk(1, 2'b11, 2'b11, 2'b11, 2'd2, 0,   8, 1, 13,  0, 0, 0, 1);
        tbl[24] = mk(0, 2'b00, 2'b00, 2'b00, 2'd1, 1,   8, 1, 13,  0, 0, 0, 1);
        tbl[25] = mk(0, 2'b00, 2'b00, 2'b00, 2'd0, 1,   8, 1, 13,  0, 0, 0, 0);

        res = 1'b0; tvalid = 1'b0; tuser = '0; flit_ret = '0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tready",     32'(tready),         32'd0);
        chk("rst_credit_cnt", 32'(credit_cnt),     32'd8);
        chk("rst_pkt_cnt",    pkt_cnt,             32'd0);
        chk("rst_in_pkt",     32'(in_pkt),         32'd0);
        chk("rst_errors",     32'({err_no_hdr, err_hdr_in_pkt, err_cred_ovf}), 32'd0);
        chk("rst_stall_cnt",  stall_cnt,           32'd0);
        res = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            compare_out(i);
        end

        // Open a packet, then pull reset asynchronously between clock edges.
        drive(mk(1, 2'b01, 2'b01, 2'b00, 2'd0, 0, 7, 1, 13, 1, 0, 0, 0));
        @(posedge clk);
        #1;
        compare_out(NVEC);
        tvalid = 1'b0; tuser = '0;
        #2 res = 1'b0;
        #1;
        chk("async_rst_in_pkt",     32'(in_pkt),     32'd0);
        chk("async_rst_tready",     32'(tready),     32'd0);
        chk("async_rst_credit_cnt", 32'(credit_cnt), 32'd8);
        chk("async_rst_pkt_cnt",    pkt_cnt,         32'd0);
        res = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_tready", 32'(tready), 32'd1);

        // Drain all credits, then hold tvalid against tready=0 for five edges.
        tvalid = 1'b1;
        tuser  = {26'b0, 2'b11, 2'b11, 2'b11};
        repeat (4) @(posedge clk);
        #1;
        chk("drain_credit_cnt", 32'(credit_cnt), 32'd0);
        chk("drain_tready",     32'(tready),     32'd0);
        chk("drain_pkt_cnt",    pkt_cnt,         32'd8);
        repeat (5) @(posedge clk);
        #1;
`ifdef AXI_RSP_FC_STATS_EN
        chk("stall_cnt", stall_cnt, 32'd5);
`else
        chk("stall_cnt", stall_cnt, 32'd0);
`endif
        chk("stall_credit_cnt", 32'(credit_cnt), 32'd0);
        chk("stall_pkt_cnt",    pkt_cnt,         32'd8);
        tvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
